// File: rtl/rrf_commit_unit_if.sv
// Dispatch / writeback / retire bundle of the rename-register-file commit unit.
// master: the pipeline side (drives dispatch and writeback, observes retire).
// slave:  the commit unit itself.
interface rrf_commit_unit_if #(
  parameter int RRF_SEL = 6
);
  // dispatch: one RRF entry allocated per cycle
  logic               dp_valid_i;
  logic [RRF_SEL-1:0] dp_rrftag_i;
  logic               dp_dstval_i;
  logic [4:0]         dp_dstnum_i;
  // writeback: one entry completed per cycle
  logic               wb_valid_i;
  logic [RRF_SEL-1:0] wb_rrftag_i;
  // retire results
  logic [1:0]         com_inst_num_o;
  logic [RRF_SEL-1:0] comptr_o;
  logic               arfwe1_o;
  logic [4:0]         dstarf1_o;
  logic [RRF_SEL-1:0] rrftag1_o;
  logic               arfwe2_o;
  logic [4:0]         dstarf2_o;
  logic [RRF_SEL-1:0] rrftag2_o;
  logic [RRF_SEL:0]   inflight_o;
  logic               alloc_err_o;

  modport master (
    output dp_valid_i, dp_rrftag_i, dp_dstval_i, dp_dstnum_i,
    output wb_valid_i, wb_rrftag_i,
    input  com_inst_num_o, comptr_o,
    input  arfwe1_o, dstarf1_o, rrftag1_o,
    input  arfwe2_o, dstarf2_o, rrftag2_o,
    input  inflight_o, alloc_err_o
  );

  modport slave (
    input  dp_valid_i, dp_rrftag_i, dp_dstval_i, dp_dstnum_i,
    input  wb_valid_i, wb_rrftag_i,
    output com_inst_num_o, comptr_o,
    output arfwe1_o, dstarf1_o, rrftag1_o,
    output arfwe2_o, dstarf2_o, rrftag2_o,
    output inflight_o, alloc_err_o
  );
endinterface

// File: rtl/rrf_commit_unit.sv
// In-order commit unit for a rename register file (RRF).
// Tracks valid/finished/destination per entry, retires up to two finished
// entries per cycle from the commit pointer, and keeps an in-flight count.
// Build option: define COMMIT_DUAL_EN for two retire slots per cycle;
// without it only slot 1 exists and slot 2 outputs are tied to zero.
module rrf_commit_unit #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rrf_commit_unit_if.slave   bus
);

  logic [RRF_NUM-1:0] valid;
  logic [RRF_NUM-1:0] finished;
  logic [RRF_NUM-1:0] dstval;
  logic [4:0]         dstnum [RRF_NUM];

  logic [RRF_SEL-1:0] comptr;
  logic [RRF_SEL:0]   inflight;
  logic [RRF_SEL:0]   inflight_next;
  logic [RRF_SEL+2:0] inflight_sum;
  logic               alloc_err;

  logic               slot1;
  logic               slot2;
  logic [1:0]         com_num;
  logic               alloc_conflict;

  logic [RRF_NUM-1:0] alloc_hit;
  logic [RRF_NUM-1:0] wb_hit;
  logic [RRF_NUM-1:0] retire_vec;

`ifdef COMMIT_DUAL_EN
  logic [RRF_SEL-1:0] comptr_p1;
  assign comptr_p1 = comptr + RRF_SEL'(1);
  // slot 2 only retires behind slot 1, keeping retirement strictly in order
  assign slot2 = slot1 && valid[comptr_p1] && finished[comptr_p1];
`else
  assign slot2 = 1'b0;
`endif

  // Retire eligibility looks only at registered state; an empty window never retires.
  assign slot1   = (inflight != '0) && valid[comptr] && finished[comptr];
  assign com_num = {1'b0, slot1} + {1'b0, slot2};

  // Per-entry decode of dispatch, writeback and retire targets.
  for (genvar gi = 0; gi < RRF_NUM; gi++) begin : g_entry_dec
    assign alloc_hit[gi] = bus.dp_valid_i && (bus.dp_rrftag_i == RRF_SEL'(gi));
    assign wb_hit[gi]    = bus.wb_valid_i && (bus.wb_rrftag_i == RRF_SEL'(gi));
`ifdef COMMIT_DUAL_EN
    assign retire_vec[gi] = (slot1 && (comptr == RRF_SEL'(gi))) ||
                            (slot2 && (comptr_p1 == RRF_SEL'(gi)));
`else
    assign retire_vec[gi] = slot1 && (comptr == RRF_SEL'(gi));
`endif
  end

  // An allocation onto a live entry is an error unless that entry retires this cycle.
  assign alloc_conflict = bus.dp_valid_i && valid[bus.dp_rrftag_i] &&
                          !retire_vec[bus.dp_rrftag_i];

  // Next in-flight count, clamped to the range 0..RRF_NUM.
  always_comb begin
    inflight_sum = {2'b00, inflight}
                 + {{(RRF_SEL+2){1'b0}}, bus.dp_valid_i}
                 - {{(RRF_SEL+1){1'b0}}, com_num};
    if (inflight_sum[RRF_SEL+2]) begin
      inflight_next = '0;
    end else if (inflight_sum[RRF_SEL+1:0] > (RRF_SEL+2)'(RRF_NUM)) begin
      inflight_next = (RRF_SEL+1)'(RRF_NUM);
    end else begin
      inflight_next = inflight_sum[RRF_SEL:0];
    end
  end

  // Entry status bits: allocation beats retirement, retirement beats writeback.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid    <= '0;
      finished <= '0;
    end else begin
      for (int i = 0; i < RRF_NUM; i++) begin
        if (alloc_hit[i]) begin
          valid[i]    <= 1'b1;
          finished[i] <= 1'b0;
        end else if (retire_vec[i]) begin
          valid[i]    <= 1'b0;
          finished[i] <= 1'b0;
        end else if (wb_hit[i] && valid[i]) begin
          finished[i] <= 1'b1;
        end
      end
    end
  end

  // Destination payload; only meaningful while the entry is valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (bus.dp_valid_i) begin
      dstval[bus.dp_rrftag_i] <= bus.dp_dstval_i;
      dstnum[bus.dp_rrftag_i] <= bus.dp_dstnum_i;
    end
  end

  // Commit pointer, in-flight count and sticky allocation error.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      comptr    <= '0;
      inflight  <= '0;
      alloc_err <= 1'b0;
    end else begin
      comptr   <= comptr + RRF_SEL'(com_num);
      inflight <= inflight_next;
      if (alloc_conflict) begin
        alloc_err <= 1'b1;
      end
    end
  end

  assign bus.com_inst_num_o = com_num;
  assign bus.comptr_o       = comptr;
  assign bus.inflight_o     = inflight;
  assign bus.alloc_err_o    = alloc_err;

  assign bus.arfwe1_o  = slot1 && dstval[comptr];
  assign bus.dstarf1_o = dstnum[comptr];
  assign bus.rrftag1_o = comptr;

`ifdef COMMIT_DUAL_EN
  assign bus.arfwe2_o  = slot2 && dstval[comptr_p1];
  assign bus.dstarf2_o = dstnum[comptr_p1];
  assign bus.rrftag2_o = comptr_p1;
`else
  assign bus.arfwe2_o  = 1'b0;
  assign bus.dstarf2_o = '0;
  assign bus.rrftag2_o = '0;
`endif

endmodule

// File: tb/tb_rrf_commit_unit.sv
// Bench for rrf_commit_unit: directed vector table, hand-written corner
// sequences (stall, wrap, overflow error, async reset) and random traffic,
// all compared against an entry-level reference model of the commit rules.
module tb_rrf_commit_unit;

  localparam int N   = 64;
  localparam int SEL = 6;
`ifdef COMMIT_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rrf_commit_unit_if #(.RRF_SEL(SEL)) bus ();

  rrf_commit_unit #(.RRF_NUM(N), .RRF_SEL(SEL)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one record per RRF entry plus pointer/count/error.
  bit m_v [N];
  bit m_f [N];
  bit m_dv[N];
  int m_dst[N];
  int m_ptr;
  int m_inf;
  bit m_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_f[i] = 0; m_dv[i] = 0; m_dst[i] = 0;
    end
    m_ptr = 0; m_inf = 0; m_err = 0;
  endfunction

  // How many entries retire this cycle: a run of finished entries at the head.
  function automatic int model_num();
    int p1;
    if (m_inf == 0) return 0;
    if (!(m_v[m_ptr] && m_f[m_ptr])) return 0;
    p1 = (m_ptr + 1) % N;
    if (DUAL && m_v[p1] && m_f[p1]) return 2;
    return 1;
  endfunction

  function automatic bit model_retiring(input int tag);
    int n = model_num();
    for (int k = 0; k < n; k++)
      if ((m_ptr + k) % N == tag) return 1;
    return 0;
  endfunction

  function automatic void model_step(input bit dv, input int tag, input bit dval,
                                     input int dnum, input bit wv, input int wtag);
    int n = model_num();
    bit tag_live = m_v[tag];
    bit tag_ret = model_retiring(tag);
    if (wv && m_v[wtag]) m_f[wtag] = 1;
    for (int k = 0; k < n; k++) begin
      m_v[(m_ptr + k) % N] = 0;
      m_f[(m_ptr + k) % N] = 0;
    end
    if (dv) begin
      if (tag_live && !tag_ret) m_err = 1;
      m_v[tag] = 1; m_f[tag] = 0; m_dv[tag] = dval; m_dst[tag] = dnum;
    end
    m_inf = m_inf + int'(dv) - n;
    if (m_inf < 0) m_inf = 0;
    if (m_inf > N) m_inf = N;
    m_ptr = (m_ptr + n) % N;
  endfunction

  task automatic compare_model();
    int n = model_num();
    int p1 = (m_ptr + 1) % N;
    bit we1 = (n >= 1) && m_dv[m_ptr];
    bit we2 = (n == 2) && m_dv[p1];
    chk("model_com", int'(bus.com_inst_num_o), n);
    chk("model_we1", int'(bus.arfwe1_o), int'(we1));
    if (we1) begin
      chk("model_dst1", int'(bus.dstarf1_o), m_dst[m_ptr]);
      chk("model_tag1", int'(bus.rrftag1_o), m_ptr);
    end
    chk("model_we2", int'(bus.arfwe2_o), int'(we2));
    if (we2) begin
      chk("model_dst2", int'(bus.dstarf2_o), m_dst[p1]);
      chk("model_tag2", int'(bus.rrftag2_o), p1);
    end
    chk("model_ptr", int'(bus.comptr_o), m_ptr);
    chk("model_inf", int'(bus.inflight_o), m_inf);
    chk("model_err", int'(bus.alloc_err_o), int'(m_err));
  endtask

  // One clock: drive at the falling edge, then compare state #1 after the rising edge.
  task automatic cycle(input bit dv, input int tag, input bit dval, input int dnum,
                       input bit wv, input int wtag);
    @(negedge clk);
    bus.dp_valid_i  = dv;
    bus.dp_rrftag_i = SEL'(tag);
    bus.dp_dstval_i = dval;
    bus.dp_dstnum_i = 5'(dnum);
    bus.wb_valid_i  = wv;
    bus.wb_rrftag_i = SEL'(wtag);
    @(posedge clk);
    #1;
    model_step(dv, tag, dval, dnum, wv, wtag);
    compare_model();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_com"}, int'(bus.com_inst_num_o), 0);
    chk({nm, "_we1"}, int'(bus.arfwe1_o), 0);
    chk({nm, "_we2"}, int'(bus.arfwe2_o), 0);
    chk({nm, "_ptr"}, int'(bus.comptr_o), 0);
    chk({nm, "_inf"}, int'(bus.inflight_o), 0);
    chk({nm, "_err"}, int'(bus.alloc_err_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.dp_valid_i = 0;
    bus.wb_valid_i = 0;
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  typedef struct {
    bit dv; int tag; bit dval; int dnum; bit wv; int wtag;
    int e_com; bit e_we1; int e_d1; int e_t1; bit e_we2; int e_d2; int e_t2;
    int e_ptr; int e_inf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bus.dp_valid_i = 0; bus.dp_rrftag_i = '0; bus.dp_dstval_i = 0; bus.dp_dstnum_i = '0;
    bus.wb_valid_i = 0; bus.wb_rrftag_i = '0;
    model_clear();

    // Two-entry allocate / out-of-order writeback / retire; expectations after each edge.
    tbl[0] = '{1, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1};
    tbl[1] = '{1, 1, 1, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 2};
    tbl[2] = '{0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 2};
    if (DUAL) begin
      tbl[3] = '{0, 0, 0, 0, 1, 0,  2, 1, 3, 0, 1, 5, 1,  0, 2};
      tbl[4] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  2, 0};
    end else begin
      tbl[3] = '{0, 0, 0, 0, 1, 0,  1, 1, 3, 0, 0, 0, 0,  0, 2};
      tbl[4] = '{0, 0, 0, 0, 0, 0,  1, 1, 5, 1, 0, 0, 0,  1, 1};
    end
    tbl[5] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  2, 0};

    repeat (2) @(posedge clk);
    do_reset();
    for (int r = 0; r < 6; r++) begin
      cycle(tbl[r].dv, tbl[r].tag, tbl[r].dval, tbl[r].dnum, tbl[r].wv, tbl[r].wtag);
      chk($sformatf("tbl%0d_com", r), int'(bus.com_inst_num_o), tbl[r].e_com);
      chk($sformatf("tbl%0d_we1", r), int'(bus.arfwe1_o), int'(tbl[r].e_we1));
      if (tbl[r].e_we1) begin
        chk($sformatf("tbl%0d_dst1", r), int'(bus.dstarf1_o), tbl[r].e_d1);
        chk($sformatf("tbl%0d_tag1", r), int'(bus.rrftag1_o), tbl[r].e_t1);
      end
      chk($sformatf("tbl%0d_we2", r), int'(bus.arfwe2_o), int'(tbl[r].e_we2));
      if (tbl[r].e_we2) begin
        chk($sformatf("tbl%0d_dst2", r), int'(bus.dstarf2_o), tbl[r].e_d2);
        chk($sformatf("tbl%0d_tag2", r), int'(bus.rrftag2_o), tbl[r].e_t2);
      end
      chk($sformatf("tbl%0d_ptr", r), int'(bus.comptr_o), tbl[r].e_ptr);
      chk($sformatf("tbl%0d_inf", r), int'(bus.inflight_o), tbl[r].e_inf);
    end

    // Head not finished blocks retirement of a finished younger entry.
    do_reset();
    cycle(1, 0, 1, 7, 0, 0);
    cycle(1, 1, 1, 8, 0, 0);
    cycle(1, 2, 1, 9, 1, 1);
    chk("stall_com_a", int'(bus.com_inst_num_o), 0);
    idle();
    chk("stall_com_b", int'(bus.com_inst_num_o), 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("stall_release_com", int'(bus.com_inst_num_o), DUAL ? 2 : 1);
    idle();
    chk("stall_release_ptr", int'(bus.comptr_o), DUAL ? 2 : 1);

    // Pointer wrap: march the commit pointer to 63, then retire 63 and 0 together.
    do_reset();
    for (int i = 0; i < 63; i++) cycle(1, i, 0, i % 32, i > 0, i - 1);
    cycle(0, 0, 0, 0, 1, 62);
    repeat (3) idle();
    chk("wrap_ptr63", int'(bus.comptr_o), 63);
    chk("wrap_inf0", int'(bus.inflight_o), 0);
    cycle(1, 63, 1, 1, 0, 0);
    cycle(1, 0, 1, 2, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 63);
    chk("wrap_com", int'(bus.com_inst_num_o), DUAL ? 2 : 1);
    chk("wrap_tag1", int'(bus.rrftag1_o), 63);
    chk("wrap_we1", int'(bus.arfwe1_o), 1);
    if (DUAL) chk("wrap_tag2", int'(bus.rrftag2_o), 0);
    repeat (2) idle();
    chk("wrap_ptr1", int'(bus.comptr_o), 1);

    // Fill every entry, then overwrite a live one: sticky error, count saturates.
    do_reset();
    for (int i = 0; i < N; i++) cycle(1, i, 1, i % 32, 0, 0);
    chk("full_inf", int'(bus.inflight_o), N);
    chk("full_err0", int'(bus.alloc_err_o), 0);
    cycle(1, 0, 1, 4, 0, 0);
    chk("ovr_err", int'(bus.alloc_err_o), 1);
    chk("ovr_inf_sat", int'(bus.inflight_o), N);
    repeat (3) idle();
    chk("ovr_err_sticky", int'(bus.alloc_err_o), 1);

    // Asynchronous reset in the middle of traffic clears outputs without a clock edge.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, i, 1, i + 10, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    idle();
    chk("post_rst_com", int'(bus.com_inst_num_o), 0);
    chk("post_rst_inf", int'(bus.inflight_o), 0);
    idle();

    // Random legal traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int n = model_num();
      int aptr = (m_ptr + m_inf) % N;
      bit dv = ($urandom_range(2) != 0) && ((m_inf < N) || (n > 0));
      bit wv = $urandom_range(1) == 1;
      int wtag = (m_inf > 0 && $urandom_range(3) != 0) ?
                 (m_ptr + int'($urandom_range(m_inf - 1))) % N : int'($urandom_range(N - 1));
      if (m_inf == N && n > 0) aptr = m_ptr;
      cycle(dv, aptr, 1'($urandom_range(1)), int'($urandom_range(31)), wv, wtag);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
